// File: rtl/piso_serializer.sv
`timescale 1ns/1ps
// piso_serializer: parallel-in serial-out transmitter.
// A WIDTH-bit word is accepted through a valid/ready handshake and then
// shifted onto sout one bit per clk. sframe marks the valid bits, and done
// pulses during the last bit of each word. A new word may be accepted during
// the last-bit cycle, so consecutive words are sent with no idle cycle.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sframe,
  output logic             done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Returns the bit that goes on the line next, according to the bit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Moves the next bit into the head position.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             accept;

  // Ready in IDLE or on the last bit of a word; held low while in reset.
  assign din_ready = rst & ((state == IDLE) | (cnt == CNT_ZERO));
  assign accept    = din_valid & din_ready;

  // Next-state logic: load on accept, shift while a word is in flight, and
  // clear the datapath on leaving SHIFT so no bits can leak later.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          shreg_nxt = din;
          cnt_nxt   = CNT_LAST;
        end else begin
          state_nxt = IDLE;
          shreg_nxt = {WIDTH{1'b0}};
          cnt_nxt   = CNT_ZERO;
        end
      end
      SHIFT: begin
        if (cnt == CNT_ZERO) begin
          if (accept) begin
            state_nxt = SHIFT;
            shreg_nxt = din;
            cnt_nxt   = CNT_LAST;
          end else begin
            state_nxt = IDLE;
            shreg_nxt = {WIDTH{1'b0}};
            cnt_nxt   = CNT_ZERO;
          end
        end else begin
          state_nxt = SHIFT;
          shreg_nxt = shift_one(shreg);
          cnt_nxt   = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        shreg_nxt = {WIDTH{1'b0}};
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, datapath and registered line outputs; outputs are derived from the
  // next state so they line up with the bit held at the shift-register head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      shreg  <= {WIDTH{1'b0}};
      cnt    <= CNT_ZERO;
      sout   <= 1'b0;
      sframe <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      sout   <= (state_nxt == SHIFT) ? head_bit(shreg_nxt) : 1'b0;
      sframe <= (state_nxt == SHIFT);
      done   <= (state_nxt == SHIFT) && (cnt_nxt == CNT_ZERO);
    end
  end

endmodule
